// File: rtl/fifo_rd_arbiter.sv
// Round-robin read-port scheduler for the dual-clock FIFO: grants one consumer at a
// time for up to BURST pops. Define FIFO_ARB_STATS_EN to add pop_total/stall_cnt.
module fifo_rd_arbiter #(
  parameter  int DSIZE = 8,
  parameter  int NREQ  = 4,
  parameter  int BURST = 4,
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW    = $clog2(BURST) + 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             rempty,
  input  logic [DSIZE-1:0] read_data,
  output logic             rinc,
  output logic [NREQ-1:0]  gnt,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output logic [IW-1:0]    out_id,
  output logic             burst_done
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]      pop_total,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [IW-1:0]    r_cur;
  logic [IW-1:0]    r_last;
  logic [CW-1:0]    r_cnt;
  logic [DSIZE-1:0] r_out_data;
  logic             r_out_valid;
  logic [IW-1:0]    r_out_id;
  logic             r_burst_done;

  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic             w_rinc;
  logic             w_exit;

  // Scan last+1, last+2, ... (mod NREQ); the first requester wins.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(r_last) + k) % NREQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_pick  = IW'(j);
      end
    end
  end

  assign w_rinc = (r_state == S_XFER) & req[r_cur] & ~rempty;
  assign w_exit = (r_state == S_XFER) &
                  ((w_rinc & (r_cnt == CW'(BURST - 1))) | ~req[r_cur] | rempty);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_cur        <= '0;
      r_last       <= IW'(NREQ - 1);
      r_cnt        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_id     <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_out_valid  <= w_rinc;
      r_burst_done <= 1'b0;
      if (w_rinc) begin
        r_out_data <= read_data;
        r_out_id   <= r_cur;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found && !rempty) begin
            r_gnt   <= NREQ'(1) << w_pick;
            r_cur   <= w_pick;
            r_cnt   <= '0;
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_rinc) r_cnt <= r_cnt + CW'(1);
          // Exit wins over the increment so cnt is always zero at the next grant.
          if (w_exit) begin
            r_gnt        <= '0;
            r_last       <= r_cur;
            r_cnt        <= '0;
            r_burst_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rinc       = w_rinc;
  assign gnt        = r_gnt;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_id     = r_out_id;
  assign burst_done = r_burst_done;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_pop_total;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_pop_total <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_rinc && r_pop_total != 16'hFFFF) r_pop_total <= r_pop_total + 16'd1;
      if (r_state == S_XFER && req[r_cur] && rempty && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign pop_total = r_pop_total;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: a behavioural FIFO model feeds the read port,
// a negedge monitor logs grants/outputs, and each scenario checks hand-computed values.
module tb_fifo_rd_arbiter;
  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic [NREQ-1:0]  req;
  logic             rempty;
  logic [DSIZE-1:0] read_data;
  logic             rinc;
  logic [NREQ-1:0]  gnt;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic [1:0]       out_id;
  logic             burst_done;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]      pop_total;
  logic [15:0]      stall_cnt;
`endif

  fifo_rd_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .req(req), .rempty(rempty), .read_data(read_data),
    .rinc(rinc), .gnt(gnt), .out_data(out_data), .out_valid(out_valid),
    .out_id(out_id), .burst_done(burst_done)
`ifdef FIFO_ARB_STATS_EN
    , .pop_total(pop_total), .stall_cnt(stall_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  // FIFO model: pointer pair over a 128-entry store
  logic [DSIZE-1:0] mem [0:127];
  logic [31:0]      rptr = '0;
  logic [31:0]      wptr = '0;
  assign rempty    = (rptr == wptr);
  assign read_data = mem[rptr[6:0]];
  always @(posedge rclk) if (rinc) rptr <= rptr + 1;

  // monitor
  int              ov_id[$];
  int              ov_dat[$];
  int              gl[$];
  int              bd_n = 0;
  logic [NREQ-1:0] prev_gnt = '0;
  always @(negedge rclk) begin
    if (out_valid) begin
      ov_id.push_back(int'(out_id));
      ov_dat.push_back(int'(out_data));
    end
    if (burst_done) bd_n++;
    if (gnt != 0 && prev_gnt == 0)
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gl.push_back(i);
    prev_gnt = gnt;
  end

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] rp0   = '0;
  logic [31:0] st;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge rclk);
      #1;
    end
  endtask

  task automatic push(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem[wptr[6:0]] = DSIZE'(base + i);
      wptr = wptr + 1;
    end
  endtask

  task automatic clr();
    ov_id.delete(); ov_dat.delete(); gl.delete(); bd_n = 0;
  endtask

  task automatic do_reset();
    req    = '0;
    rrst_n = 1'b0;
    step(2);
    wptr   = rptr;
    rrst_n = 1'b1;
    rp0    = rptr;
    clr();
  endtask

  task automatic wait_pops(input int n, input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (rptr - st == 32'(n)) begin ok = 1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    rrst_n = 1'b0;
    req    = '0;
    step(2);
    chk("rst_gnt",   32'(gnt),        32'd0);
    chk("rst_rinc",  32'(rinc),       32'd0);
    chk("rst_ovld",  32'(out_valid),  32'd0);
    chk("rst_odat",  32'(out_data),   32'd0);
    chk("rst_oid",   32'(out_id),     32'd0);
    chk("rst_bdone", 32'(burst_done), 32'd0);

    // 1: three words, consumer 0 alone; burst ends on empty
    do_reset();
    push(3, 'hA1); mem[1] = 8'hB2; mem[2] = 8'hC3;
    mem[wptr[6:0]-7'd2] = 8'hB2; mem[wptr[6:0]-7'd1] = 8'hC3;
    req = 4'b0001;
    step();
    chk("t1_gnt", 32'(gnt), 32'd1);
    step(8);
    chk("t1_nout", 32'(ov_id.size()), 32'd3);
    if (ov_id.size() == 3) begin
      chk("t1_d0", 32'(ov_dat[0]), 32'hA1);
      chk("t1_d1", 32'(ov_dat[1]), 32'hB2);
      chk("t1_d2", 32'(ov_dat[2]), 32'hC3);
      chk("t1_id", 32'(ov_id[0] | ov_id[1] | ov_id[2]), 32'd0);
    end
    chk("t1_bdone", 32'(bd_n), 32'd1);
    chk("t1_gnt0", 32'(gnt), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    chk("t1_pops",  32'(pop_total), 32'd3);
    chk("t1_stall", 32'(stall_cnt), 32'd1);
`endif
    req = '0;

    // 2: sixteen words, everyone requesting -> 0,1,2,3 with four pops each
    do_reset();
    push(16, 'h10);
    req = 4'b1111;
    for (int c = 0; c < 200 && rptr != wptr; c++) step();
    step(3);
    chk("t2_ngnt", 32'(gl.size()), 32'd4);
    for (int k = 0; k < 4 && k < gl.size(); k++) chk("t2_order", 32'(gl[k]), 32'(k));
    chk("t2_nout", 32'(ov_id.size()), 32'd16);
    for (int k = 0; k < 16 && k < ov_id.size(); k++) begin
      chk("t2_id",  32'(ov_id[k]),  32'(k / 4));
      chk("t2_dat", 32'(ov_dat[k]), 32'('h10 + k));
    end
    chk("t2_bdone", 32'(bd_n), 32'd4);
    req = '0;

    // 3: consumer 2 drops its request after two pops
    do_reset();
    push(10, 'h30);
    st  = rptr;
    req = 4'b0100;
    wait_pops(2, "t3_timeout");
    req = '0;
    step();
    chk("t3_gnt0",  32'(gnt),        32'd0);
    chk("t3_bdone", 32'(burst_done), 32'd1);
    step(3);
    chk("t3_nout", 32'(ov_id.size()), 32'd2);
    if (ov_id.size() == 2) begin
      chk("t3_id0", 32'(ov_id[0]), 32'd2);
      chk("t3_id1", 32'(ov_id[1]), 32'd2);
      chk("t3_d1",  32'(ov_dat[1]), 32'h31);
    end
    chk("t3_left", wptr - rptr, 32'd8);

    // 4: after consumer 1, req 0011 scans 2,3,0 -> 0; then 1 again
    do_reset();
    push(2, 'h50);
    req = 4'b0010;
    step(8);
    req = 4'b0011;
    push(1, 'h60);
    step(6);
    push(1, 'h61);
    step(6);
    req = '0;
    chk("t4_ngnt", 32'(gl.size()), 32'd3);
    if (gl.size() == 3) begin
      chk("t4_g0", 32'(gl[0]), 32'd1);
      chk("t4_g1", 32'(gl[1]), 32'd0);
      chk("t4_g2", 32'(gl[2]), 32'd1);
    end
    chk("t4_nout", 32'(ov_id.size()), 32'd4);
    if (ov_id.size() == 4) begin
      chk("t4_id2",  32'(ov_id[2]),  32'd0);
      chk("t4_dat2", 32'(ov_dat[2]), 32'h60);
    end

    // 5: async reset mid-burst, then arbitration restarts at consumer 0
    do_reset();
    push(1, 'h70);
    req = 4'b0010;
    step(6);
    push(5, 'h80);
    st  = rptr;
    req = 4'b0100;
    wait_pops(1, "t5_timeout");
    chk("t5_pre_ovld", 32'(out_valid), 32'd1);
    chk("t5_pre_gnt",  32'(gnt),       32'd4);
    #1 rrst_n = 1'b0;
    #1;
    chk("t5_gnt",  32'(gnt),       32'd0);
    chk("t5_rinc", 32'(rinc),      32'd0);
    chk("t5_ovld", 32'(out_valid), 32'd0);
    st = rptr;
    step(3);
    chk("t5_nopop", rptr, st);
    rrst_n = 1'b1;
    rp0    = rptr;
    clr();
    req = 4'b1111;
    step(3);
    chk("t5_ngnt", 32'(gl.size() > 0), 32'd1);
    if (gl.size() > 0) chk("t5_first", 32'(gl[0]), 32'd0);
    step(10);
    req = '0;
`ifdef FIFO_ARB_STATS_EN
    chk("t5_pops", 32'(pop_total), rptr - rp0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
